axi4_lite_regbank_slave: RTL and testbench
==========================================

Name: axi4_lite_regbank_slave

Overview:
AXI4-Lite responder: a bank of memory-mapped registers that answers read and write transactions from an AXI4-Lite initiator. Write (AW/W/B) and read (AR/R) channels are handled by independent FSMs. Registers 0..NUM_REGS-2 are read/write with byte strobes. Register NUM_REGS-1 is a read-only status word. Register 0 is also driven out as a control word for local logic.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
ADDRESS, 32, address bus width.
NUM_REGS, 16, number of registers; power of 2, at least 2.

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESET  input  1  synchronous active-high reset
S_AWADDR  input  ADDRESS  write address
S_AWVALID  input  1  write address valid
S_AWREADY  output  1  write address ready
S_WDATA  input  DATA_WIDTH  write data
S_WSTRB  input  DATA_WIDTH/8  byte strobes
S_WVALID  input  1  write data valid
S_WREADY  output  1  write data ready
S_BRESP  output  2  write response
S_BVALID  output  1  write response valid
S_BREADY  input  1  write response ready
S_ARADDR  input  ADDRESS  read address
S_ARVALID  input  1  read address valid
S_ARREADY  output  1  read address ready
S_RDATA  output  DATA_WIDTH  read data
S_RRESP  output  2  read response
S_RVALID  output  1  read data valid
S_RREADY  input  1  read data ready
STATUS_IN  input  DATA_WIDTH  value returned by register NUM_REGS-1
CTRL_OUT  output  DATA_WIDTH  current value of register 0

Behaviour:
- Reset (ARESET=1 at an edge):
  - All registers are cleared to 0, so CTRL_OUT=0.
  - All ready/valid outputs are 0; BRESP=0, RRESP=0, RDATA=0.
  - Both FSMs go to their IDLE state and the aw_held/w_held flags are cleared.
  - Any transaction in flight is dropped with no response.
  - In the first cycle after reset is released, AWREADY, WREADY and ARREADY are 1.
- All outputs are registered.
- Address decode:
  - Byte offset bits addr[log2(DATA_WIDTH/8)-1:0] are ignored.
  - Register index is the next log2(NUM_REGS) bits.
  - An address at or above NUM_REGS*DATA_WIDTH/8 is out of range and gets DECERR (2'b11).
  - Writing register NUM_REGS-1 gets SLVERR (2'b10); no state changes.
  - All other accesses get OKAY (2'b00).
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AWREADY = !aw_held and WREADY = !w_held.
  - An AW handshake latches the address and sets aw_held. A W handshake latches data and strobes and sets w_held.
  - AW and W may arrive in either order or in the same cycle.
  - On the edge where both are held (after the later handshake), the FSM:
    - commits the write, updating only the byte lanes whose WSTRB bit is 1;
    - sets BRESP and BVALID=1;
    - drops AWREADY and WREADY to 0;
    - clears both held flags;
    - moves to W_RESP.
  - Latency: BVALID is high in the cycle after the later of the two handshakes.
  - In W_RESP, BVALID and BRESP hold until BREADY=1. On that edge BVALID goes to 0 and the FSM returns to W_IDLE; the readies are 1 in the following cycle.
  - WSTRB=0 gives OKAY with no register change.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, ARREADY=1.
  - On an AR handshake the FSM registers RDATA and RRESP, sets RVALID=1 and ARREADY=0, and moves to R_DATA.
  - Latency is 1 cycle after the handshake.
  - RDATA for an error response is 0.
  - In R_DATA, RVALID, RDATA and RRESP stay stable until RREADY=1. On that edge RVALID goes to 0; ARREADY is 1 in the next cycle.
  - Sustained rate is 1 read per 2 cycles when RREADY is tied high.
- Simultaneous read and write:
  - The channels are independent.
  - If a read is captured on the same edge as a write commit to the same register, the read returns the pre-write value.
  - Status reads sample STATUS_IN on the AR-capture edge.
- VALID inputs are not required to stay asserted for the block to function. Only handshakes (valid & ready at an edge) are acted on.

Test Plan:
- Write then read: AW=0x04 and W=0xDEADBEEF with WSTRB=0xF in the same cycle -> BVALID 1 cycle later with BRESP=OKAY; then read 0x04 -> RDATA=0xDEADBEEF, RRESP=OKAY, RVALID 1 cycle after the AR handshake.
- Byte strobes and split arrival: reg0=0x11223344; W=0xAABBCCDD with WSTRB=0b0101 sent 3 cycles before AW=0x00 -> WREADY low after the W handshake, BVALID 1 cycle after the AW handshake, CTRL_OUT=0x11BB33DD.
- Errors: write 0x3C (status register) -> BRESP=SLVERR, no change; read 0x40 -> RRESP=DECERR, RDATA=0; read 0x3C with STATUS_IN=0xCAFE0001 -> RDATA=0xCAFE0001, OKAY.
- Backpressure: hold BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0 throughout; hold RREADY=0 for 4 cycles -> RDATA stable and ARREADY=0.
- Read/write collision: reg2=0x5, then commit write 0x9 to 0x08 on the same edge as the AR handshake for 0x08 -> RDATA=0x5; a subsequent read returns 0x9.
- Reset mid-transaction: W handshake done, AW pending, ARESET pulsed for 1 cycle -> all registers 0, no BVALID issued, all readies 1 in the first cycle after reset; a fresh write completes normally.

Source files
------------

// File: rtl/axi4_lite_regbank_slave_if.sv
// AXI4-Lite bus bundle for the register bank: AW/W/B write channels and AR/R read channels.
interface axi4_lite_regbank_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDRESS    = 32
);
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_regbank_slave.sv
// AXI4-Lite register bank. Registers 0..NUM_REGS-2 are read/write with byte strobes,
// register NUM_REGS-1 reads STATUS_IN and rejects writes, register 0 drives CTRL_OUT.
// Write and read channels run independent two-state FSMs; every output is a flop.
module axi4_lite_regbank_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  axi4_lite_regbank_slave_if.slave        bus,
  input  logic [DATA_WIDTH-1:0]           STATUS_IN,
  output logic [DATA_WIDTH-1:0]           CTRL_OUT
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb  = $clog2(StrbW);
  localparam int unsigned IdxW     = $clog2(NUM_REGS);
  localparam int unsigned RangeLsb = AddrLsb + IdxW;
  localparam logic [IdxW-1:0] StatusIdx = IdxW'(NUM_REGS - 1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic {StWIdle, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  function automatic logic [IdxW-1:0] reg_idx(input logic [ADDRESS-1:0] addr);
    return addr[AddrLsb +: IdxW];
  endfunction

  // Any address bit above the register window set means out of range.
  function automatic logic in_range(input logic [ADDRESS-1:0] addr);
    return (addr >> RangeLsb) == '0;
  endfunction

  // Register storage excludes the status word, which has no backing flop.
  logic [DATA_WIDTH-1:0] regs_q [0:NUM_REGS-2];
  logic [DATA_WIDTH-1:0] regs_d [0:NUM_REGS-2];

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;

  assign aw_hs = bus.S_AWVALID & awready_q;
  assign w_hs  = bus.S_WVALID & wready_q;
  assign ar_hs = bus.S_ARVALID & arready_q;

  // Write channel: collect AW and W in any order, commit once both are held, then respond on B.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    case (w_state_q)
      StWIdle: begin
        if (aw_hs) begin
          awaddr_d  = bus.S_AWADDR;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = bus.S_WDATA;
          wstrb_d  = bus.S_WSTRB;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) begin
          if (!in_range(awaddr_d)) begin
            bresp_d = RespDecerr;
          end else if (reg_idx(awaddr_d) == StatusIdx) begin
            bresp_d = RespSlverr;
          end else begin
            bresp_d = RespOkay;
            for (int unsigned b = 0; b < StrbW; b++) begin
              if (wstrb_d[b]) begin
                regs_d[reg_idx(awaddr_d)][8*b +: 8] = wdata_d[8*b +: 8];
              end
            end
          end
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = StWResp;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      StWResp: begin
        if (bus.S_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = StWIdle;
        end
      end
      default: w_state_d = StWIdle;
    endcase
  end

  // Read channel: capture on AR handshake from pre-commit register state, hold R until accepted.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      StRIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          if (!in_range(bus.S_ARADDR)) begin
            rdata_d = '0;
            rresp_d = RespDecerr;
          end else if (reg_idx(bus.S_ARADDR) == StatusIdx) begin
            rdata_d = STATUS_IN;
            rresp_d = RespOkay;
          end else begin
            rdata_d = regs_q[reg_idx(bus.S_ARADDR)];
            rresp_d = RespOkay;
          end
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = StRData;
        end
      end
      StRData: begin
        if (bus.S_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = StRIdle;
        end
      end
      default: r_state_d = StRIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q    <= '{default: '0};
      w_state_q <= StWIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= StRIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      regs_q    <= regs_d;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.S_AWREADY = awready_q;
  assign bus.S_WREADY  = wready_q;
  assign bus.S_BVALID  = bvalid_q;
  assign bus.S_BRESP   = bresp_q;
  assign bus.S_ARREADY = arready_q;
  assign bus.S_RVALID  = rvalid_q;
  assign bus.S_RDATA   = rdata_q;
  assign bus.S_RRESP   = rresp_q;
  assign CTRL_OUT      = regs_q[0];

endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// Bench for the AXI4-Lite register bank: reset checks, a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a word-array reference model.
module tb_axi4_lite_regbank_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] status_in;
  logic [DW-1:0] ctrl_out;

  always #5 clk = ~clk;

  axi4_lite_regbank_slave_if #(.DATA_WIDTH(DW), .ADDRESS(AW)) bus ();

  axi4_lite_regbank_slave #(
    .DATA_WIDTH(DW),
    .ADDRESS   (AW),
    .NUM_REGS  (NR)
  ) dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .bus      (bus),
    .STATUS_IN(status_in),
    .CTRL_OUT (ctrl_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ref_regs [NR];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] status;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_resp(input logic [31:0] a, input bit wr);
    int unsigned word = a / 4;
    if (word >= NR) return 2'b11;
    if (wr && word == NR - 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] mask = '0;
    if (model_resp(a, 1'b1) != 2'b00) return;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    ref_regs[a / 4] = (ref_regs[a / 4] & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] st);
    if (model_resp(a, 1'b0) != 2'b00) return 32'h0;
    if (a / 4 == NR - 1) return st;
    return ref_regs[a / 4];
  endfunction

  // ---------------- bus tasks (enter and leave just after a rising edge) ----------------
  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output bit ok);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int n = 0;
    bus.S_AWADDR = a;
    bus.S_WDATA  = d;
    bus.S_WSTRB  = s;
    while (!(aw_done && w_done) && n < 40) begin
      bus.S_AWVALID = !aw_done && (n >= aw_dly);
      bus.S_WVALID  = !w_done && (n >= w_dly);
      @(negedge clk);
      aw_f = bus.S_AWVALID && bus.S_AWREADY;
      w_f  = bus.S_WVALID && bus.S_WREADY;
      @(posedge clk); #1;
      aw_done = aw_done || aw_f;
      w_done  = w_done || w_f;
      n++;
    end
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    ok = aw_done && w_done;
  endtask

  task automatic send_read(input logic [31:0] a, output bit ok);
    bit done = 0;
    int n = 0;
    bus.S_ARADDR = a;
    while (!done && n < 40) begin
      bus.S_ARVALID = 1'b1;
      @(negedge clk);
      done = bus.S_ARREADY;
      @(posedge clk); #1;
      n++;
    end
    bus.S_ARVALID = 1'b0;
    ok = done;
  endtask

  task automatic collect_b(output logic [1:0] r, output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.S_BVALID && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    r = bus.S_BRESP;
    bus.S_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_BREADY = 1'b0;
  endtask

  task automatic collect_r(output logic [31:0] d, output logic [1:0] r, output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.S_RVALID && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    d = bus.S_RDATA;
    r = bus.S_RRESP;
    bus.S_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_RREADY = 1'b0;
  endtask

  // Full write with response; checks handshake, 1-cycle B latency and response code.
  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp);
    bit ok;
    logic [1:0] r;
    int lat;
    send_write(a, d, s, aw_dly, w_dly, ok);
    check({nm, " wr handshake"}, 32'(ok), 32'd1);
    collect_b(r, lat);
    check({nm, " bvalid latency"}, 32'(lat), 32'd0);
    check({nm, " bresp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    bit ok;
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    send_read(a, ok);
    check({nm, " rd handshake"}, 32'(ok), 32'd1);
    collect_r(d, r, lat);
    check({nm, " rvalid latency"}, 32'(lat), 32'd0);
    check({nm, " rresp"}, 32'(r), 32'(exp_resp));
    check({nm, " rdata"}, d, exp_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, st;
    logic [3:0]  s;
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    int          lat;
    bit          ok;

    vecs[0]  = '{1'b1, 32'h04,   32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h04,   32'h0,        4'h0, 32'h0,        2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h07,   32'h0,        4'h0, 32'h0,        2'b00, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h3C,   32'h12345678, 4'hF, 32'h0,        2'b10, 32'h0};
    vecs[4]  = '{1'b0, 32'h3C,   32'h0,        4'h0, 32'hCAFE0001, 2'b00, 32'hCAFE0001};
    vecs[5]  = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h0,        2'b11, 32'h0};
    vecs[6]  = '{1'b1, 32'h40,   32'h11111111, 4'hF, 32'h0,        2'b11, 32'h0};
    vecs[7]  = '{1'b1, 32'h08,   32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h08,   32'h0,        4'h0, 32'h0,        2'b00, 32'h0};
    vecs[9]  = '{1'b1, 32'h0C,   32'h0A0B0C0D, 4'h3, 32'h0,        2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0C,   32'h0,        4'h0, 32'h0,        2'b00, 32'h00000C0D};
    vecs[11] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        2'b11, 32'h0};
    vecs[12] = '{1'b1, 32'h38,   32'h55AA55AA, 4'hF, 32'h0,        2'b00, 32'h0};
    vecs[13] = '{1'b0, 32'h38,   32'h0,        4'h0, 32'h0,        2'b00, 32'h55AA55AA};

    rst = 1'b1;
    status_in = '0;
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0;  bus.S_WSTRB = '0; bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0;
    bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst awready", 32'(bus.S_AWREADY), 32'd0);
    check("rst wready", 32'(bus.S_WREADY), 32'd0);
    check("rst arready", 32'(bus.S_ARREADY), 32'd0);
    check("rst bvalid", 32'(bus.S_BVALID), 32'd0);
    check("rst rvalid", 32'(bus.S_RVALID), 32'd0);
    check("rst bresp", 32'(bus.S_BRESP), 32'd0);
    check("rst rresp", 32'(bus.S_RRESP), 32'd0);
    check("rst rdata", bus.S_RDATA, 32'h0);
    check("rst ctrl_out", ctrl_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-rst awready", 32'(bus.S_AWREADY), 32'd1);
    check("post-rst wready", 32'(bus.S_WREADY), 32'd1);
    check("post-rst arready", 32'(bus.S_ARREADY), 32'd1);
    @(posedge clk); #1;

    // ---- directed vector table ----
    foreach (vecs[i]) begin
      status_in = vecs[i].status;
      if (vecs[i].wr)
        do_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0,
                 vecs[i].exp_resp);
      else
        do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_rdata);
    end

    // ---- strobes with W arriving three cycles before AW ----
    do_write("split pre", 32'h00, 32'h11223344, 4'hF, 0, 0, 2'b00);
    bus.S_WDATA = 32'hAABBCCDD;
    bus.S_WSTRB = 4'b0101;
    bus.S_WVALID = 1'b1;
    @(negedge clk);
    check("split wready before", 32'(bus.S_WREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("split wready low c%0d", c), 32'(bus.S_WREADY), 32'd0);
      check($sformatf("split awready c%0d", c), 32'(bus.S_AWREADY), 32'd1);
      check($sformatf("split no bvalid c%0d", c), 32'(bus.S_BVALID), 32'd0);
      @(posedge clk); #1;
    end
    bus.S_AWADDR = 32'h00;
    bus.S_AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AWVALID = 1'b0;
    @(negedge clk);
    check("split bvalid", 32'(bus.S_BVALID), 32'd1);
    check("split bresp", 32'(bus.S_BRESP), 32'd0);
    check("split ctrl_out", ctrl_out, 32'h11BB33DD);
    @(posedge clk); #1;
    collect_b(rd_r, lat);

    // ---- backpressure ----
    send_write(32'h10, 32'h600DF00D, 4'hF, 0, 0, ok);
    check("bp wr handshake", 32'(ok), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp bvalid c%0d", c), 32'(bus.S_BVALID), 32'd1);
      check($sformatf("bp bresp c%0d", c), 32'(bus.S_BRESP), 32'd0);
      check($sformatf("bp awready c%0d", c), 32'(bus.S_AWREADY), 32'd0);
      check($sformatf("bp wready c%0d", c), 32'(bus.S_WREADY), 32'd0);
      @(posedge clk); #1;
    end
    collect_b(rd_r, lat);
    @(negedge clk);
    check("bp bvalid dropped", 32'(bus.S_BVALID), 32'd0);
    check("bp awready back", 32'(bus.S_AWREADY), 32'd1);
    check("bp wready back", 32'(bus.S_WREADY), 32'd1);
    @(posedge clk); #1;
    send_read(32'h10, ok);
    check("bp rd handshake", 32'(ok), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp rvalid c%0d", c), 32'(bus.S_RVALID), 32'd1);
      check($sformatf("bp rdata c%0d", c), bus.S_RDATA, 32'h600DF00D);
      check($sformatf("bp arready c%0d", c), 32'(bus.S_ARREADY), 32'd0);
      @(posedge clk); #1;
    end
    collect_r(rd_d, rd_r, lat);
    @(negedge clk);
    check("bp arready back", 32'(bus.S_ARREADY), 32'd1);
    @(posedge clk); #1;

    // ---- read/write collision on register 2 ----
    do_write("coll pre", 32'h08, 32'h5, 4'hF, 0, 0, 2'b00);
    bus.S_AWADDR = 32'h08; bus.S_WDATA = 32'h9; bus.S_WSTRB = 4'hF;
    bus.S_ARADDR = 32'h08;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_ARVALID = 1'b1;
    @(negedge clk);
    check("coll all ready", 32'(bus.S_AWREADY && bus.S_WREADY && bus.S_ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    collect_r(rd_d, rd_r, lat);
    check("coll rvalid latency", 32'(lat), 32'd0);
    check("coll old rdata", rd_d, 32'h5);
    collect_b(rd_r, lat);
    check("coll bresp", 32'(rd_r), 32'd0);
    do_read("coll post", 32'h08, 2'b00, 32'h9);

    // ---- reset with W held and AW still pending ----
    bus.S_WDATA = 32'hBAD0BAD0; bus.S_WSTRB = 4'hF; bus.S_WVALID = 1'b1;
    bus.S_AWADDR = 32'h04;
    @(posedge clk); #1;
    bus.S_WVALID = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-rst ctrl_out", ctrl_out, 32'h0);
    check("mid-rst bvalid", 32'(bus.S_BVALID), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-rst awready", 32'(bus.S_AWREADY), 32'd1);
    check("mid-rst wready", 32'(bus.S_WREADY), 32'd1);
    check("mid-rst arready", 32'(bus.S_ARREADY), 32'd1);
    check("mid-rst no bvalid", 32'(bus.S_BVALID), 32'd0);
    @(posedge clk); #1;
    do_read("mid-rst reg1", 32'h04, 2'b00, 32'h0);
    do_read("mid-rst reg14", 32'h38, 2'b00, 32'h0);
    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    do_write("mid-rst fresh", 32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b00);
    model_write(32'h00, 32'hA5A5A5A5, 4'hF);
    check("mid-rst fresh ctrl_out", ctrl_out, 32'hA5A5A5A5);
    do_read("mid-rst untouched reg1", 32'h04, 2'b00, 32'h0);

    // ---- randomized traffic against the reference model ----
    for (int i = 0; i < 150; i++) begin
      a  = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      st = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write($sformatf("rnd%0d", i), a, d, s, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), model_resp(a, 1'b1));
        model_write(a, d, s);
      end else begin
        status_in = st;
        do_read($sformatf("rnd%0d", i), a, model_resp(a, 1'b0), model_read(a, st));
      end
      check($sformatf("rnd%0d ctrl_out", i), ctrl_out, ref_regs[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
